// File: rtl/tank_dist_seq.sv
// Register-tank distribution sequencer: latches one channel per gate class at minor-cycle
// start and holds the tank/polarity gates open for WORD_LEN digit pulses. Optional err flag: TANK_DIST_SEQ_ERR_EN.
module tank_dist_seq #(
   parameter int NUM_REG  = 4,
   parameter int WORD_LEN = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mc_start,
   input  logic               digit_pulse,
   input  logic [NUM_REG-1:0] dec_in_up,
   input  logic [NUM_REG-1:0] dec_in_down,
   input  logic [NUM_REG-1:0] dec_out_up,
   input  logic [NUM_REG-1:0] dec_out_down,
   input  logic               f7_pos,
   input  logic               f8_pos,
   output logic [NUM_REG-1:0] t_in_up,
   output logic [NUM_REG-1:0] t_in_down,
   output logic [NUM_REG-1:0] t_out_up,
   output logic [NUM_REG-1:0] t_out_down,
   output logic [NUM_REG-1:0] f7_pos_up,
   output logic [NUM_REG-1:0] f7_neg_up,
   output logic [NUM_REG-1:0] f8_pos_up,
   output logic [NUM_REG-1:0] f8_neg_up,
   output logic [NUM_REG-1:0] f7_pos_down,
   output logic [NUM_REG-1:0] f7_neg_down,
   output logic [NUM_REG-1:0] f8_pos_down,
   output logic [NUM_REG-1:0] f8_neg_down,
`ifdef TANK_DIST_SEQ_ERR_EN
   output logic               err,
`endif
   output logic               busy
);

   localparam int CW = $clog2(WORD_LEN + 1);
   localparam logic [NUM_REG-1:0] ONE      = NUM_REG'(1);
   localparam logic [CW-1:0]      LAST_CNT = CW'(WORD_LEN - 1);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [NUM_REG-1:0] sel_iu_q, sel_id_q, sel_ou_q, sel_od_q;
   logic [NUM_REG-1:0] sel_iu_d, sel_id_d, sel_ou_d, sel_od_d;
   logic [NUM_REG-1:0] up_d, down_d;
   logic               any_req, accept, pol_en;

   // Isolates the lowest set bit: v & (two's complement of v).
   function automatic logic [NUM_REG-1:0] lowest_bit(input logic [NUM_REG-1:0] v);
      return v & (~v + ONE);
   endfunction

   function automatic logic multi_bit(input logic [NUM_REG-1:0] v);
      return |(v & (v - ONE));
   endfunction

   assign any_req = |{dec_in_up, dec_in_down, dec_out_up, dec_out_down};
   assign accept  = (state_q == IDLE) && mc_start && any_req;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sel_iu_d = sel_iu_q;
      sel_id_d = sel_id_q;
      sel_ou_d = sel_ou_q;
      sel_od_d = sel_od_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               sel_iu_d = lowest_bit(dec_in_up);
               sel_id_d = lowest_bit(dec_in_down);
               sel_ou_d = lowest_bit(dec_out_up);
               sel_od_d = lowest_bit(dec_out_down);
               cnt_d    = '0;
               state_d  = XFER;
            end
         end
         XFER: begin
            if (digit_pulse) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) state_d = DONE;
            end
         end
         DONE: begin
            sel_iu_d = '0;
            sel_id_d = '0;
            sel_ou_d = '0;
            sel_od_d = '0;
            cnt_d    = '0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Polarity gates are registered from next-state values so they are zero outside XFER
   // and show f7/f8 with one cycle of latency inside it.
   assign up_d   = sel_iu_d | sel_ou_d;
   assign down_d = sel_id_d | sel_od_d;
   assign pol_en = (state_d == XFER);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sel_iu_q    <= '0;
         sel_id_q    <= '0;
         sel_ou_q    <= '0;
         sel_od_q    <= '0;
         f7_pos_up   <= '0;
         f7_neg_up   <= '0;
         f8_pos_up   <= '0;
         f8_neg_up   <= '0;
         f7_pos_down <= '0;
         f7_neg_down <= '0;
         f8_pos_down <= '0;
         f8_neg_down <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sel_iu_q    <= sel_iu_d;
         sel_id_q    <= sel_id_d;
         sel_ou_q    <= sel_ou_d;
         sel_od_q    <= sel_od_d;
         f7_pos_up   <= pol_en ? (up_d   &  {NUM_REG{f7_pos}}) : '0;
         f7_neg_up   <= pol_en ? (up_d   & ~{NUM_REG{f7_pos}}) : '0;
         f8_pos_up   <= pol_en ? (up_d   &  {NUM_REG{f8_pos}}) : '0;
         f8_neg_up   <= pol_en ? (up_d   & ~{NUM_REG{f8_pos}}) : '0;
         f7_pos_down <= pol_en ? (down_d &  {NUM_REG{f7_pos}}) : '0;
         f7_neg_down <= pol_en ? (down_d & ~{NUM_REG{f7_pos}}) : '0;
         f8_pos_down <= pol_en ? (down_d &  {NUM_REG{f8_pos}}) : '0;
         f8_neg_down <= pol_en ? (down_d & ~{NUM_REG{f8_pos}}) : '0;
      end
   end

   assign busy       = (state_q == XFER);
   assign t_in_up    = busy ? sel_iu_q : '0;
   assign t_in_down  = busy ? sel_id_q : '0;
   assign t_out_up   = busy ? sel_ou_q : '0;
   assign t_out_down = busy ? sel_od_q : '0;

`ifdef TANK_DIST_SEQ_ERR_EN
   logic err_set;

   // A dropped mc_start or a multi-bit class on the accepted cycle latches err until reset.
   assign err_set = (mc_start && (state_q != IDLE)) ||
                    (accept && (multi_bit(dec_in_up)  || multi_bit(dec_in_down) ||
                                multi_bit(dec_out_up) || multi_bit(dec_out_down)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          err <= 1'b0;
      else if (err_set) err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_tank_dist_seq.sv
// Self-checking bench for tank_dist_seq: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a window-level behavioural model.
module tb_tank_dist_seq;

   localparam int NR = 4;
   localparam int WL = 18;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          mc_start = 1'b0;
   logic          digit_pulse = 1'b0;
   logic [NR-1:0] dec_in_up = '0, dec_in_down = '0, dec_out_up = '0, dec_out_down = '0;
   logic          f7_pos = 1'b0, f8_pos = 1'b0;
   logic [NR-1:0] t_in_up, t_in_down, t_out_up, t_out_down;
   logic [NR-1:0] f7_pos_up, f7_neg_up, f8_pos_up, f8_neg_up;
   logic [NR-1:0] f7_pos_down, f7_neg_down, f8_pos_down, f8_neg_down;
   logic          busy;
`ifdef TANK_DIST_SEQ_ERR_EN
   logic          err;
`endif

   tank_dist_seq #(.NUM_REG(NR), .WORD_LEN(WL)) dut (
      .clk(clk), .rst(rst), .mc_start(mc_start), .digit_pulse(digit_pulse),
      .dec_in_up(dec_in_up), .dec_in_down(dec_in_down),
      .dec_out_up(dec_out_up), .dec_out_down(dec_out_down),
      .f7_pos(f7_pos), .f8_pos(f8_pos),
      .t_in_up(t_in_up), .t_in_down(t_in_down), .t_out_up(t_out_up), .t_out_down(t_out_down),
      .f7_pos_up(f7_pos_up), .f7_neg_up(f7_neg_up), .f8_pos_up(f8_pos_up), .f8_neg_up(f8_neg_up),
      .f7_pos_down(f7_pos_down), .f7_neg_down(f7_neg_down),
      .f8_pos_down(f8_pos_down), .f8_neg_down(f8_neg_down),
`ifdef TANK_DIST_SEQ_ERR_EN
      .err(err),
`endif
      .busy(busy)
   );

   // clock
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: one transfer window = latch, count WL pulses, one dead cycle
   bit            m_busy = 0, m_done = 0, m_f7 = 0, m_f8 = 0, m_err = 0;
   int            m_pulses = 0;
   logic [NR-1:0] m_iu = '0, m_id = '0, m_ou = '0, m_od = '0;

   function automatic logic [NR-1:0] first_set(input logic [NR-1:0] v);
      logic [NR-1:0] r;
      r = '0;
      for (int i = 0; i < NR; i++) begin
         if (v[i]) begin
            r[i] = 1'b1;
            return r;
         end
      end
      return r;
   endfunction

   function automatic int ones(input logic [NR-1:0] v);
      int n = 0;
      for (int i = 0; i < NR; i++) n += int'(v[i]);
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0; m_done = 0; m_err = 0; m_pulses = 0; m_f7 = 0; m_f8 = 0;
         m_iu = '0; m_id = '0; m_ou = '0; m_od = '0;
      end else begin
         if (m_busy) begin
            if (mc_start) m_err = 1;
            if (digit_pulse) begin
               m_pulses++;
               if (m_pulses == WL) begin
                  m_busy = 0;
                  m_done = 1;
               end
            end
         end else if (m_done) begin
            if (mc_start) m_err = 1;
            m_done = 0;
            m_iu = '0; m_id = '0; m_ou = '0; m_od = '0;
         end else if (mc_start && (|{dec_in_up, dec_in_down, dec_out_up, dec_out_down})) begin
            m_iu = first_set(dec_in_up);
            m_id = first_set(dec_in_down);
            m_ou = first_set(dec_out_up);
            m_od = first_set(dec_out_down);
            if (ones(dec_in_up) > 1 || ones(dec_in_down) > 1 ||
                ones(dec_out_up) > 1 || ones(dec_out_down) > 1) m_err = 1;
            m_busy   = 1;
            m_pulses = 0;
         end
         m_f7 = f7_pos;
         m_f8 = f8_pos;
      end
   end

   // scoreboard compare on the falling edge
   always @(negedge clk) begin
      logic [NR-1:0] up, dn, zero;
      zero = '0;
      up   = m_busy ? (m_iu | m_ou) : zero;
      dn   = m_busy ? (m_id | m_od) : zero;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("t_in_up", 32'(t_in_up), 32'(m_busy ? m_iu : zero));
      chk("t_in_down", 32'(t_in_down), 32'(m_busy ? m_id : zero));
      chk("t_out_up", 32'(t_out_up), 32'(m_busy ? m_ou : zero));
      chk("t_out_down", 32'(t_out_down), 32'(m_busy ? m_od : zero));
      chk("f7_pos_up", 32'(f7_pos_up), 32'(m_f7 ? up : zero));
      chk("f7_neg_up", 32'(f7_neg_up), 32'(m_f7 ? zero : up));
      chk("f8_pos_up", 32'(f8_pos_up), 32'(m_f8 ? up : zero));
      chk("f8_neg_up", 32'(f8_neg_up), 32'(m_f8 ? zero : up));
      chk("f7_pos_down", 32'(f7_pos_down), 32'(m_f7 ? dn : zero));
      chk("f7_neg_down", 32'(f7_neg_down), 32'(m_f7 ? zero : dn));
      chk("f8_pos_down", 32'(f8_pos_down), 32'(m_f8 ? dn : zero));
      chk("f8_neg_down", 32'(f8_neg_down), 32'(m_f8 ? zero : dn));
`ifdef TANK_DIST_SEQ_ERR_EN
      chk("err", 32'(err), 32'(m_err));
`endif
   end

   // driver tasks: each call is one clock with the given inputs, returning #1 after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic mc, input logic dp, input logic [NR-1:0] iu,
                        input logic [NR-1:0] id, input logic [NR-1:0] ou, input logic [NR-1:0] od);
      mc_start = mc; digit_pulse = dp;
      dec_in_up = iu; dec_in_down = id; dec_out_up = ou; dec_out_down = od;
      tick();
      mc_start = 1'b0; digit_pulse = 1'b0;
      dec_in_up = '0; dec_in_down = '0; dec_out_up = '0; dec_out_down = '0;
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b1, '0, '0, '0, '0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_t_in_up", 32'(t_in_up), 32'd0);

      // one 18-pulse window on channel 2 in-up
      drive(1'b1, 1'b0, 4'b0100, '0, '0, '0);
      chk("win_busy", 32'(busy), 32'd1);
      chk("win_t_in_up", 32'(t_in_up), 32'h4);
      pulses(WL - 1);
      chk("win_pulse17_t_in_up", 32'(t_in_up), 32'h4);
      pulses(1);
      chk("win_done_busy", 32'(busy), 32'd0);
      chk("win_done_t_in_up", 32'(t_in_up), 32'd0);
      drive(1'b0, 1'b0, '0, '0, '0, '0);
      chk("win_idle_t_in_up", 32'(t_in_up), 32'd0);

      // multi-bit class resolves to lowest index
      drive(1'b1, 1'b0, '0, '0, '0, 4'b1010);
      chk("lowbit_t_out_down", 32'(t_out_down), 32'h2);
`ifdef TANK_DIST_SEQ_ERR_EN
      chk("lowbit_err", 32'(err), 32'd1);
`endif
      pulses(WL);
      drive(1'b0, 1'b0, '0, '0, '0, '0);

      // polarity follows f7_pos one cycle later
      f7_pos = 1'b1;
      drive(1'b1, 1'b0, 4'b0010, '0, '0, '0);
      chk("pol_f7_pos_up_hi", 32'(f7_pos_up), 32'h2);
      chk("pol_f7_neg_up_hi", 32'(f7_neg_up), 32'h0);
      f7_pos = 1'b0;
      pulses(1);
      chk("pol_f7_pos_up_lo", 32'(f7_pos_up), 32'h0);
      chk("pol_f7_neg_up_lo", 32'(f7_neg_up), 32'h2);
      for (int i = 0; i < 40 && busy; i++) pulses(1);
      chk("pol_window_closed", 32'(busy), 32'd0);
      drive(1'b0, 1'b0, '0, '0, '0, '0);

      // reset mid-window, then a fresh full window
      drive(1'b1, 1'b0, 4'b0001, '0, 4'b0001, '0);
      pulses(9);
      rst = 1'b1;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_t_in_up", 32'(t_in_up), 32'd0);
      chk("rst_f7_neg_up", 32'(f7_neg_up), 32'd0);
      tick();
      rst = 1'b0;
      drive(1'b1, 1'b0, '0, 4'b0001, '0, '0);
      chk("fresh_t_in_down", 32'(t_in_down), 32'h1);
      pulses(WL - 1);
      chk("fresh_busy_before_last", 32'(busy), 32'd1);
      pulses(1);
      chk("fresh_busy_after_last", 32'(busy), 32'd0);
      drive(1'b0, 1'b0, '0, '0, '0, '0);

      // repeated mc_start mid-window is dropped
      drive(1'b1, 1'b0, 4'b0001, '0, '0, '0);
      pulses(5);
      drive(1'b1, 1'b0, 4'b1000, '0, '0, '0);
      chk("repeat_t_in_up", 32'(t_in_up), 32'h1);
`ifdef TANK_DIST_SEQ_ERR_EN
      chk("repeat_err", 32'(err), 32'd1);
`endif
      pulses(WL - 6);
      chk("repeat_held", 32'(t_in_up), 32'h1);
      pulses(1);
      chk("repeat_done", 32'(busy), 32'd0);
      drive(1'b0, 1'b0, '0, '0, '0, '0);

      // mc_start with no decoder request stays idle
      drive(1'b1, 1'b0, '0, '0, '0, '0);
      chk("empty_busy", 32'(busy), 32'd0);
      chk("empty_t_out_up", 32'(t_out_up), 32'd0);

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         mc_start     = ($urandom_range(0, 7) == 0);
         digit_pulse  = ($urandom_range(0, 2) != 0);
         dec_in_up    = ($urandom_range(0, 2) == 0) ? NR'($urandom_range(0, (1 << NR) - 1)) : '0;
         dec_in_down  = ($urandom_range(0, 2) == 0) ? NR'($urandom_range(0, (1 << NR) - 1)) : '0;
         dec_out_up   = ($urandom_range(0, 2) == 0) ? NR'($urandom_range(0, (1 << NR) - 1)) : '0;
         dec_out_down = ($urandom_range(0, 2) == 0) ? NR'($urandom_range(0, (1 << NR) - 1)) : '0;
         if ($urandom_range(0, 3) == 0) f7_pos = ~f7_pos;
         if ($urandom_range(0, 3) == 0) f8_pos = ~f8_pos;
         if ($urandom_range(0, 599) == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end else begin
            tick();
         end
      end
      drive(1'b0, 1'b0, '0, '0, '0, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
